pwm_capture: RTL

Receive-side counterpart to the team's PWM generators. Samples an asynchronous PWM line and measures the high time and period of each cycle in `clk` cycles. From the high time it recovers the 3-bit duty code the generator was driven with, and it flags a line that has stopped toggling. It sits on the board-test path, fed by the generator output through a pin or loopback, and reports to status registers.

---
 rtl/pwm_capture.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of an asynchronous PWM line and recovers the duty code.
// Optional high-time/period tolerance check is enabled by defining PWM_CAPTURE_TOL_EN.
module pwm_capture #(
  parameter int CBITS = 11,
  parameter int TOL   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic             meas_valid,
  output logic [CBITS:0]   high_cnt,
  output logic [CBITS:0]   period_cnt,
  output logic [2:0]       duty_code,
  output logic             code_err,
  output logic             stuck,
  output logic             stuck_level
);

  localparam int W = CBITS + 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic           s1_q, s2_q, s3_q;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   hi_lat_q, hi_lat_d;
  state_t         state_q, state_d;
  logic           meas_valid_q, meas_valid_d;
  logic [W-1:0]   high_cnt_q, high_cnt_d;
  logic [W-1:0]   period_cnt_q, period_cnt_d;
  logic [2:0]     duty_code_q, duty_code_d;
  logic           code_err_q, code_err_d;
  logic           stuck_q, stuck_d;
  logic           stuck_level_q, stuck_level_d;

  logic           rise, fall, cnt_sat;
  logic           err_calc;

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign cnt_sat = &cnt_q;

`ifdef PWM_CAPTURE_TOL_EN
  logic [W-1:0] nominal;
  logic [W-1:0] dev;

  // Evaluated on the values about to be published, so the flag lands with them.
  always_comb begin
    nominal  = W'({hi_lat_q[CBITS-2:CBITS-4], 1'b1}) << (CBITS - 5);
    dev      = (hi_lat_q > nominal) ? (hi_lat_q - nominal) : (nominal - hi_lat_q);
    err_calc = (dev > W'(TOL)) || (cnt_q != (W'(1) << CBITS));
  end
`else
  assign err_calc = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    meas_valid_d  = 1'b0;
    high_cnt_d    = high_cnt_q;
    period_cnt_d  = period_cnt_q;
    duty_code_d   = duty_code_q;
    code_err_d    = code_err_q;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    cnt_d    = rise ? W'(1) : (cnt_sat ? cnt_q : cnt_q + W'(1));
    hi_lat_d = fall ? cnt_q : hi_lat_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          stuck_d = 1'b0;
        end
      end
      HIGH: begin
        if (cnt_sat) begin
          state_d       = IDLE;
          stuck_d       = 1'b1;
          stuck_level_d = s2_q;
        end else if (fall) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          state_d      = HIGH;
          meas_valid_d = 1'b1;
          period_cnt_d = cnt_q;
          high_cnt_d   = hi_lat_q;
          duty_code_d  = hi_lat_q[CBITS-2:CBITS-4];
          code_err_d   = err_calc;
        end else if (cnt_sat) begin
          state_d       = IDLE;
          stuck_d       = 1'b1;
          stuck_level_d = s2_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      cnt_q         <= '0;
      hi_lat_q      <= '0;
      state_q       <= IDLE;
      meas_valid_q  <= 1'b0;
      high_cnt_q    <= '0;
      period_cnt_q  <= '0;
      duty_code_q   <= '0;
      code_err_q    <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      s1_q          <= pwm_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      cnt_q         <= cnt_d;
      hi_lat_q      <= hi_lat_d;
      state_q       <= state_d;
      meas_valid_q  <= meas_valid_d;
      high_cnt_q    <= high_cnt_d;
      period_cnt_q  <= period_cnt_d;
      duty_code_q   <= duty_code_d;
      code_err_q    <= code_err_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign meas_valid  = meas_valid_q;
  assign high_cnt    = high_cnt_q;
  assign period_cnt  = period_cnt_q;
  assign duty_code   = duty_code_q;
  assign code_err    = code_err_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule
